// File: rtl/biquad8_coeff_regs_pkg.sv
// biquad_coeff_pkg: shared constants for the biquad8 coefficient register block.
//   - default geometry (NCOEFF/CBITS/IDXBITS)
//   - byte addresses of the four registers and the word index helper
//   - CTRL register bit positions
package biquad_coeff_pkg;

  localparam int NCOEFF_DEF  = 8;
  localparam int CBITS_DEF   = 18;
  localparam int IDXBITS_DEF = 4;

  localparam logic [6:0] ADDR_CTRL   = 7'h00;
  localparam logic [6:0] ADDR_COEFF  = 7'h04;
  localparam logic [6:0] ADDR_RDSEL  = 7'h08;
  localparam logic [6:0] ADDR_RDDATA = 7'h0C;

  // CTRL write bits
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_CLEAR  = 1;
  // CTRL read bits (idx sits in the low IDXBITS bits)
  localparam int CTRL_OVF    = 16;
  localparam int CTRL_PEND   = 17;

  // Registers are word aligned; decode looks only at adr[6:2].
  function automatic logic [4:0] word_of(input logic [6:0] a);
    return a[6:2];
  endfunction

endpackage

// File: rtl/biquad8_coeff_wbs_if.sv
// biquad8_coeff_wbs_if: Wishbone classic slave front end.
//   Registered ack with one cycle latency; ack never stays high two cycles,
//   so a held strobe is acked every other cycle. Write strobes fire on the
//   accepting cycle (the edge that registers ack). Partial-select writes are
//   acked but produce no strobe. Read data is captured from the parent's
//   combinational mux on the accepting cycle.
// Ports:
//   clk, rst                  clock, async active-high reset
//   cyc, stb, we, sel, adr    Wishbone request
//   rdata                     read value for the current word (from parent)
//   ack, dat                  Wishbone response
//   word                      decoded word index, adr[6:2]
//   wr_ctrl/wr_coeff/wr_rdsel one-cycle write strobes
module biquad8_coeff_wbs_if
  import biquad_coeff_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [6:0]  adr,
  input  logic [31:0] rdata,
  output logic        ack,
  output logic [31:0] dat,
  output logic [4:0]  word,
  output logic        wr_ctrl,
  output logic        wr_coeff,
  output logic        wr_rdsel
);

  logic accept, wr;
  logic adr_unused;

  assign adr_unused = ^adr[1:0];
  assign word       = adr[6:2];
  assign accept     = cyc & stb & ~ack;
  assign wr         = accept & we & (sel == 4'hF);

  assign wr_ctrl  = wr & (word == word_of(ADDR_CTRL));
  assign wr_coeff = wr & (word == word_of(ADDR_COEFF));
  assign wr_rdsel = wr & (word == word_of(ADDR_RDSEL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0;
      dat <= '0;
    end else begin
      ack <= accept;
      dat <= (accept & ~we) ? rdata : '0;
    end
  end

endmodule

// File: rtl/biquad8_coeff_regs.sv
// biquad8_coeff_regs: staged/active coefficient sets for one biquad8 filter.
//   Host pushes coefficients into a staging array through COEFF, then commits
//   them atomically via CTRL bit0 or global_update_i. A commit request sets
//   pending; the following cycle copies staged -> active and pulses update_o.
// Optional: define BIQUAD_COEFF_READBACK_EN to get the RDSEL/RDDATA readback
//   of the active set; without it both registers read 0.
// Ports:
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   wb_cyc_i..wb_dat_i        Wishbone classic request
//   wb_dat_o, wb_ack_o        Wishbone response
//   global_update_i           external commit request pulse
//   coeff_o                   active set, coeff k at [CBITS*k +: CBITS]
//   update_o                  pulse in the cycle coeff_o takes a new set
module biquad8_coeff_regs
  import biquad_coeff_pkg::*;
#(
  parameter int NCOEFF  = NCOEFF_DEF,
  parameter int CBITS   = CBITS_DEF,
  parameter int IDXBITS = IDXBITS_DEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [6:0]              wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack_o,
  input  logic                    global_update_i,
  output logic [NCOEFF*CBITS-1:0] coeff_o,
  output logic                    update_o
);

  localparam logic [IDXBITS-1:0] IDX_FULL = IDXBITS'(NCOEFF);

  logic [NCOEFF-1:0][CBITS-1:0] staged, active;
  logic [IDXBITS-1:0]           idx;
  logic                         ovf, pending;
  logic                         wr_ctrl, wr_coeff, wr_rdsel;
  logic [4:0]                   word;
  logic [31:0]                  rdata, rd_coeff, rd_sel;
  logic                         dat_unused;

  assign dat_unused = ^wb_dat_i[31:CBITS];

  biquad8_coeff_wbs_if u_wbs (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .cyc      (wb_cyc_i),
    .stb      (wb_stb_i),
    .we       (wb_we_i),
    .sel      (wb_sel_i),
    .adr      (wb_adr_i),
    .rdata    (rdata),
    .ack      (wb_ack_o),
    .dat      (wb_dat_o),
    .word     (word),
    .wr_ctrl  (wr_ctrl),
    .wr_coeff (wr_coeff),
    .wr_rdsel (wr_rdsel)
  );

  // Commit block is last so it wins over same-cycle clear/push on idx/ovf,
  // and a request arriving on the commit cycle folds into that commit.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      staged   <= '0;
      active   <= '0;
      idx      <= '0;
      ovf      <= 1'b0;
      pending  <= 1'b0;
      update_o <= 1'b0;
    end else begin
      update_o <= 1'b0;
      if (wr_coeff) begin
        if (idx == IDX_FULL) begin
          ovf <= 1'b1;
        end else begin
          for (int k = 0; k < NCOEFF; k++)
            if (idx == IDXBITS'(k)) staged[k] <= wb_dat_i[CBITS-1:0];
          idx <= idx + 1'b1;
        end
      end
      if (wr_ctrl && wb_dat_i[CTRL_CLEAR]) begin
        idx <= '0;
        ovf <= 1'b0;
      end
      if ((wr_ctrl && wb_dat_i[CTRL_COMMIT]) || global_update_i)
        pending <= 1'b1;
      if (pending) begin
        active   <= staged;
        update_o <= 1'b1;
        pending  <= 1'b0;
        idx      <= '0;
        ovf      <= 1'b0;
      end
    end
  end

  assign coeff_o = active;

`ifdef BIQUAD_COEFF_READBACK_EN
  logic [IDXBITS-1:0] rdsel;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)      rdsel <= '0;
    else if (wr_rdsel) rdsel <= wb_dat_i[IDXBITS-1:0];
  end

  always_comb begin
    rd_coeff = '0;
    for (int k = 0; k < NCOEFF; k++)
      if (rdsel == IDXBITS'(k)) rd_coeff = 32'(signed'(active[k]));
  end

  assign rd_sel = 32'(rdsel);
`else
  logic rdsel_unused;
  assign rdsel_unused = wr_rdsel;
  assign rd_coeff     = '0;
  assign rd_sel       = '0;
`endif

  always_comb begin
    rdata = '0;
    case (word)
      word_of(ADDR_CTRL): begin
        rdata[IDXBITS-1:0] = idx;
        rdata[CTRL_OVF]    = ovf;
        rdata[CTRL_PEND]   = pending;
      end
      word_of(ADDR_RDSEL):  rdata = rd_sel;
      word_of(ADDR_RDDATA): rdata = rd_coeff;
      default:              rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_biquad8_coeff_regs.sv
// tb_biquad8_coeff_regs: directed bench for biquad8_coeff_regs.
//   Define BIQUAD_COEFF_READBACK_EN to also exercise the readback registers.
module tb_biquad8_coeff_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [6:0]   adr;
  logic [31:0]  dat_i;
  logic [31:0]  dat_o;
  logic         ack;
  logic         gu;
  logic [143:0] coeff;
  logic         upd;

  int checks = 0;
  int errors = 0;
  int npulse = 0;

  biquad8_coeff_regs dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst),
    .wb_cyc_i        (cyc),
    .wb_stb_i        (stb),
    .wb_we_i         (we),
    .wb_sel_i        (sel),
    .wb_adr_i        (adr),
    .wb_dat_i        (dat_i),
    .wb_dat_o        (dat_o),
    .wb_ack_o        (ack),
    .global_update_i (gu),
    .coeff_o         (coeff),
    .update_o        (upd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (upd) npulse++;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transfer; returns one step (#1) after the edge that registers ack.
  task automatic xfer(input logic w, input logic [6:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic g, output logic [31:0] rd);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s; gu = g;
    @(posedge clk); #1;
    gu = 1'b0;
    chk("ack", {143'd0, ack}, 144'd1);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    logic [31:0] junk;
    xfer(1'b1, a, d, 4'hF, 1'b0, junk);
    idle();
    chk("ack_width", {143'd0, ack}, 144'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] v;
    xfer(1'b0, a, 32'h0, 4'hF, 1'b0, v);
    idle();
    chk(tag, {112'd0, v}, {112'd0, exp});
  endtask

  logic [143:0] exp;
  logic [31:0]  junk;
  int           base, nack;

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 4'hF; adr = '0; dat_i = '0; gu = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_ack",   {143'd0, ack}, 144'd0);
    chk("rst_dat",   {112'd0, dat_o}, 144'd0);
    chk("rst_upd",   {143'd0, upd}, 144'd0);
    chk("rst_coeff", coeff, 144'd0);
    rd_chk("rst_ctrl", 7'h00, 32'h0);

    // Two pushes and a CTRL commit
    wr(7'h04, 32'd16384);
    wr(7'h04, 32'd8192);
    rd_chk("ctrl_idx2", 7'h00, 32'h2);
    base = npulse;
    xfer(1'b1, 7'h00, 32'h1, 4'hF, 1'b0, junk);
    chk("commit_upd_early", {143'd0, upd}, 144'd0);
    chk("commit_coeff_early", coeff, 144'd0);
    idle();
    exp = '0; exp[17:0] = 18'd16384; exp[35:18] = 18'd8192;
    chk("commit_upd", {143'd0, upd}, 144'd1);
    chk("commit_coeff", coeff, exp);
    idle();
    chk("commit_upd_low", {143'd0, upd}, 144'd0);
    chk("commit_npulse", 144'(npulse - base), 144'd1);
    rd_chk("ctrl_after_commit", 7'h00, 32'h0);

`ifdef BIQUAD_COEFF_READBACK_EN
    wr(7'h08, 32'h1);
    rd_chk("rdsel_rd", 7'h08, 32'h1);
    rd_chk("rddata_1", 7'h0C, 32'd8192);
    wr(7'h08, 32'h9);
    rd_chk("rddata_oob", 7'h0C, 32'h0);
`else
    wr(7'h08, 32'h1);
    rd_chk("rdsel_off", 7'h08, 32'h0);
    rd_chk("rddata_off", 7'h0C, 32'h0);
`endif

    // Async reset between edges clears outputs immediately
    #3 rst = 1'b1;
    #1;
    chk("arst_coeff", coeff, 144'd0);
    chk("arst_ack", {143'd0, ack}, 144'd0);
    @(posedge clk); #1 rst = 1'b0;
    rd_chk("arst_ctrl", 7'h00, 32'h0);

    // Overflow: 9 pushes, 9th dropped
    for (int i = 1; i <= 9; i++) wr(7'h04, 32'(i));
    rd_chk("ovf_ctrl", 7'h00, 32'h0001_0008);
    wr(7'h00, 32'h1);
    idle();
    exp = '0;
    for (int k = 0; k < 8; k++) exp[18*k +: 18] = 18'(k + 1);
    chk("ovf_coeff", coeff, exp);
    rd_chk("ovf_cleared", 7'h00, 32'h0);

    // Push coincident with global update lands in the commit
    wr(7'h04, 32'd7);
    base = npulse;
    xfer(1'b1, 7'h04, 32'hFFFF_FC18, 4'hF, 1'b1, junk);
    chk("gu_upd_early", {143'd0, upd}, 144'd0);
    idle();
    exp[17:0] = 18'd7; exp[35:18] = 18'h3FC18;
    chk("gu_upd", {143'd0, upd}, 144'd1);
    chk("gu_coeff", coeff, exp);
    idle(); idle();
    chk("gu_npulse", 144'(npulse - base), 144'd1);
    rd_chk("gu_ctrl", 7'h00, 32'h0);
`ifdef BIQUAD_COEFF_READBACK_EN
    wr(7'h08, 32'h1);
    rd_chk("rddata_neg", 7'h0C, 32'hFFFF_FC18);
`endif

    // Back-to-back requests collapse to one commit
    base = npulse;
    gu = 1'b1; idle(); idle(); gu = 1'b0;
    repeat (3) idle();
    chk("collapse_npulse", 144'(npulse - base), 144'd1);

    // Partial select write is acked but ignored
    xfer(1'b1, 7'h04, 32'd55, 4'h1, 1'b0, junk);
    idle();
    rd_chk("partial_sel_idx", 7'h00, 32'h0);

    // Unmapped address
    wr(7'h40, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd", 7'h40, 32'h0);
    rd_chk("unmapped_ctrl", 7'h00, 32'h0);

    // Held strobe for 6 cycles -> 3 acks
    nack = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 7'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) nack++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held_stb_acks", 144'(nack), 144'd3);
    idle();

    // Commit and clear together: commit sees staged, staging idx cleared
    wr(7'h04, 32'd21);
    wr(7'h04, 32'd22);
    wr(7'h00, 32'h3);
    idle();
    exp[17:0] = 18'd21; exp[35:18] = 18'd22;
    chk("both_coeff", coeff, exp);
    rd_chk("both_ctrl", 7'h00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
